rsa_job_scheduler: RTL and testbench
====================================

Name: rsa_job_scheduler

Overview:
- Shares one RSA_Module modular-exponentiation engine among NUM_REQ requesters, e.g. encrypt and decrypt channels from the host bridge.
- Arbitrates requests round-robin and latches the winner's operands.
- Sequences the engine's start/done handshake and returns the result to the owning requester over a valid/ready response channel.
- Adds operand checking and a watchdog timeout, so a hung or mis-configured job returns an error instead of stalling the bus.

Parameters:
- WIDTH, 12: operand/result width, identical to the engine's WIDTH.
- NUM_REQ, 2: number of requesters, range 2..8.
- TIMEOUT, 65535: maximum cycles in WAIT before an error response.
- CW, $clog2(TIMEOUT+1): watchdog counter width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted; one-hot or zero
- req_base  in  NUM_REQ*WIDTH  flattened bases; slice i = [i*WIDTH +: WIDTH]
- req_exp  in  NUM_REQ*WIDTH  flattened exponents
- req_mod  in  NUM_REQ*WIDTH  flattened moduli
- rsp_valid  out  NUM_REQ  per-requester response valid; one-hot or zero
- rsp_ready  in  NUM_REQ  per-requester response accept
- rsp_data  out  WIDTH  result, shared bus, meaningful only with rsp_valid
- rsp_err  out  2  0 = ok, 1 = bad modulus, 2 = timeout
- rsa_start  out  1  one-cycle start pulse to engine
- rsa_base, rsa_exp, rsa_mod  out  WIDTH each  registered operands to engine
- rsa_result  in  WIDTH  engine result
- rsa_done  in  1  engine done
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; rr pointer = NUM_REQ-1, so requester 0 wins first. Reset mid-job abandons the job silently.
- IDLE:
  - If any req_valid, grant is round-robin starting at (last_grant+1) mod NUM_REQ.
  - Assert req_ready[g] combinationally in the same cycle. Handshake = valid & ready.
  - Latch operands and owner, update the pointer, go to CHECK.
- CHECK (1 cycle):
  - If latched mod < 2: rsp_err=1, rsp_data=0, go to RESP without starting the engine.
  - Else, if rsa_done==0: go to ISSUE. If rsa_done==1, stay in CHECK (stale done from a prior job).
- ISSUE (1 cycle): rsa_start=1 with operands stable; clear the watchdog; go to WAIT. Operands stay stable until the next ISSUE.
- WAIT:
  - Watchdog increments each cycle.
  - On rsa_done=1: capture rsa_result, rsp_err=0, go to RESP.
  - If the counter reaches TIMEOUT first: rsp_data=0, rsp_err=2, go to RESP.
  - If done and timeout occur in the same cycle, done wins.
  - rsa_done is sampled only in WAIT and ignored elsewhere.
- RESP: rsp_valid[owner]=1 with data/err held until rsp_ready[owner]; on handshake go to IDLE. Other requesters' rsp_ready are ignored.
- Latency: handshake to rsa_start = 2 cycles; rsa_done to rsp_valid = 1 cycle; back-to-back new grant is possible the cycle after the response handshake.
- No new grant while busy; req_ready stays 0 outside IDLE. A requester dropping req_valid before grant is legal.
- Result is passed through unmodified at WIDTH bits; no arithmetic is performed in this block.

Decomposition:
- rsa_pkg:
  - state enum: IDLE, CHECK, ISSUE, WAIT, RESP.
  - error code constants: RSA_OK=0, RSA_ERR_MOD=1, RSA_ERR_TO=2.
- Sub-module rsa_rr_arbiter (parameter N): inputs req vector, advance strobe; outputs one-hot grant and index; owns the pointer register.

Test Plan:
- Req0 base=65 exp=17 mod=3233 with a real RSA_Module WIDTH=12 -> one rsa_start pulse; rsp_valid[0] with rsp_data=2790, rsp_err=0.
- Req1 base=2790 exp=2753 mod=3233 -> rsp_valid[1] with rsp_data=65, rsp_err=0.
- Both req_valid held high for 4 jobs (req0: 4^13 mod 497; req1: 65^17 mod 3233) -> grants alternate 0,1,0,1; results 445 and 2790 routed to the correct owner.
- Req0 mod=1 -> rsa_start never asserted; rsp_err=1, rsp_data=0 two cycles after the handshake.
- Stub engine that never asserts done, with TIMEOUT=20 -> rsp_err=2 after 20 WAIT cycles; busy falls after rsp_ready; the next job completes normally.
- rsp_ready held low for 10 cycles, and separately rst_n pulsed low during WAIT -> response held stable throughout; after reset all outputs are 0, state is IDLE, and the next grant goes to requester 0.

Source files
------------

// File: rtl/rsa_job_scheduler_pkg.sv
// Shared types and constants for the RSA job scheduler.
package rsa_job_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    localparam logic [1:0] RSA_OK      = 2'd0;
    localparam logic [1:0] RSA_ERR_MOD = 2'd1;
    localparam logic [1:0] RSA_ERR_TO  = 2'd2;

endpackage

// File: rtl/rsa_job_scheduler_if.sv
// Requester-side request/response bus of the RSA job scheduler.
interface rsa_job_scheduler_if #(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned NUM_REQ = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_base;
    logic [NUM_REQ*WIDTH-1:0] req_exp;
    logic [NUM_REQ*WIDTH-1:0] req_mod;
    logic [NUM_REQ-1:0]       rsp_valid;
    logic [NUM_REQ-1:0]       rsp_ready;
    logic [WIDTH-1:0]         rsp_data;
    logic [1:0]               rsp_err;

    // Requester side
    modport master (
        output req_valid, req_base, req_exp, req_mod, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_base, req_exp, req_mod, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/rsa_job_scheduler_rr_arbiter.sv
// Round-robin arbiter: searches from (pointer+1) mod N, pointer moves to the winner on advance.
module rsa_rr_arbiter
    import rsa_job_scheduler_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 adv_i,
    output logic [N-1:0]         gnt_o_c,
    output logic [$clog2(N)-1:0] idx_o_c
);
    localparam int unsigned IW = $clog2(N);

    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    // Farthest candidate first so the nearest requester after the pointer wins last
    always_comb begin
        idx_o_c = '0;
        cand    = '0;
        gnt_o_c = '0;
        for (int k = int'(N); k >= 1; k--) begin
            cand = IW'((int'(ptr_q) + k) % int'(N));
            if (req_i[cand]) begin
                idx_o_c = cand;
            end
        end
        if (|req_i) begin
            gnt_o_c[idx_o_c] = 1'b1;
        end
    end

    // Pointer next state
    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) begin
            ptr_d = idx_o_c;
        end
    end

    // Pointer register; resets to N-1 so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one modular-exponentiation engine among NUM_REQ requesters with operand check and watchdog.
module rsa_job_scheduler
    import rsa_job_scheduler_pkg::*;
#(
    parameter int unsigned WIDTH   = 12,
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned TIMEOUT = 65535,
    parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rsa_job_scheduler_if.slave    bus,
    output logic                  rsa_start,
    output logic [WIDTH-1:0]      rsa_base,
    output logic [WIDTH-1:0]      rsa_exp,
    output logic [WIDTH-1:0]      rsa_mod,
    input  logic [WIDTH-1:0]      rsa_result,
    input  logic                  rsa_done,
    output logic                  busy
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    state_e               state_q, state_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [WIDTH-1:0]     base_q, base_d, exp_q, exp_d, mod_q, mod_d;
    logic [CW-1:0]        wdog_q, wdog_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [1:0]           err_q, err_d;
    logic [NUM_REQ-1:0]   valid_q, valid_d;
    logic                 start_q, start_d;
    logic                 busy_q, busy_d;

    logic [NUM_REQ-1:0]   gnt_c;
    logic [IW-1:0]        gidx_c;
    logic                 adv_c;
    logic [NUM_REQ-1:0]   req_ready_c;
    logic [WIDTH-1:0]     base_sel_c, exp_sel_c, mod_sel_c;

    rsa_rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_i   (bus.req_valid),
        .adv_i   (adv_c),
        .gnt_o_c (gnt_c),
        .idx_o_c (gidx_c)
    );

    // Operand mux from the granted requester's slice
    always_comb begin
        base_sel_c = '0;
        exp_sel_c  = '0;
        mod_sel_c  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gnt_c[i]) begin
                base_sel_c = bus.req_base[i*WIDTH +: WIDTH];
                exp_sel_c  = bus.req_exp[i*WIDTH +: WIDTH];
                mod_sel_c  = bus.req_mod[i*WIDTH +: WIDTH];
            end
        end
    end

    // Job sequencing: next state and registered outputs
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        base_d      = base_q;
        exp_d       = exp_q;
        mod_d       = mod_q;
        wdog_d      = wdog_q;
        data_d      = data_q;
        err_d       = err_q;
        valid_d     = valid_q;
        start_d     = 1'b0;
        adv_c       = 1'b0;
        req_ready_c = '0;
        case (state_q)
            ST_IDLE: begin
                req_ready_c = gnt_c;
                if (|bus.req_valid) begin
                    adv_c   = 1'b1;
                    owner_d = gidx_c;
                    base_d  = base_sel_c;
                    exp_d   = exp_sel_c;
                    mod_d   = mod_sel_c;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (mod_q < WIDTH'(2)) begin
                    data_d          = '0;
                    err_d           = RSA_ERR_MOD;
                    valid_d         = '0;
                    valid_d[owner_q] = 1'b1;
                    state_d         = ST_RESP;
                end else if (!rsa_done) begin
                    start_d = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                wdog_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                wdog_d = wdog_q + CW'(1);
                if (rsa_done) begin
                    data_d           = rsa_result;
                    err_d            = RSA_OK;
                    valid_d          = '0;
                    valid_d[owner_q] = 1'b1;
                    state_d          = ST_RESP;
                end else if (wdog_d == CW'(TIMEOUT)) begin
                    data_d           = '0;
                    err_d            = RSA_ERR_TO;
                    valid_d          = '0;
                    valid_d[owner_q] = 1'b1;
                    state_d          = ST_RESP;
                end
            end
            ST_RESP: begin
                if (|(bus.rsp_ready & valid_q)) begin
                    valid_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers; reset abandons any job in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            mod_q   <= '0;
            wdog_q  <= '0;
            data_q  <= '0;
            err_q   <= RSA_OK;
            valid_q <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            mod_q   <= mod_d;
            wdog_q  <= wdog_d;
            data_q  <= data_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            start_q <= start_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.req_ready = req_ready_c;
    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = data_q;
    assign bus.rsp_err   = err_q;
    assign rsa_start     = start_q;
    assign rsa_base      = base_q;
    assign rsa_exp       = exp_q;
    assign rsa_mod       = mod_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_rsa_job_scheduler.sv
// Directed scoreboard bench for rsa_job_scheduler with a behavioural exponentiation engine.
module tb_rsa_job_scheduler;
    localparam int unsigned W  = 12;
    localparam int unsigned NR = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rsa_start, rsa_done, busy;
    logic [W-1:0] rsa_base, rsa_exp, rsa_mod;
    logic [W-1:0] rsa_result;

    rsa_job_scheduler_if #(.WIDTH(W), .NUM_REQ(NR)) bus ();

    rsa_job_scheduler #(.WIDTH(W), .NUM_REQ(NR), .TIMEOUT(20)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .rsa_start  (rsa_start),
        .rsa_base   (rsa_base),
        .rsa_exp    (rsa_exp),
        .rsa_mod    (rsa_mod),
        .rsa_result (rsa_result),
        .rsa_done   (rsa_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural engine: result appears four cycles after start; hang suppresses done
    logic         eng_hang = 1'b0;
    logic         stale_done = 1'b0;
    logic         eng_done_q;
    logic [W-1:0] eng_res_q;
    int           eng_cnt;
    int           start_cnt = 0;

    function automatic logic [W-1:0] modexp(input logic [W-1:0] b, input logic [W-1:0] e,
                                            input logic [W-1:0] m);
        logic [31:0] r, x, mm;
        mm = 32'(m);
        r  = 32'd1;
        x  = 32'(b) % mm;
        for (int i = 0; i < int'(W); i++) begin
            if (e[i]) r = (r * x) % mm;
            x = (x * x) % mm;
        end
        return W'(r % mm);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eng_done_q <= 1'b0;
            eng_res_q  <= '0;
            rsa_result <= '0;
            eng_cnt    <= 0;
        end else begin
            eng_done_q <= 1'b0;
            if (rsa_start) begin
                eng_cnt   <= 4;
                eng_res_q <= modexp(rsa_base, rsa_exp, rsa_mod);
            end else if (eng_cnt > 0) begin
                eng_cnt <= eng_cnt - 1;
                if (eng_cnt == 1 && !eng_hang) begin
                    eng_done_q <= 1'b1;
                    rsa_result <= eng_res_q;
                end
            end
        end
    end
    assign rsa_done = eng_done_q | stale_done;

    always @(posedge clk) if (rsa_start) start_cnt <= start_cnt + 1;

    typedef struct { int owner; int data; int err; } exp_t;
    exp_t sb[$];
    int   tests = 0;
    int   errs  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic push(input int owner, input int data, input int err);
        exp_t e;
        e.owner = owner; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    // Present a request and return just after its handshake edge
    task automatic send(input int idx, input logic [W-1:0] b, input logic [W-1:0] e,
                        input logic [W-1:0] m);
        int n = 0;
        bus.req_base[idx*W +: W] = b;
        bus.req_exp[idx*W +: W]  = e;
        bus.req_mod[idx*W +: W]  = m;
        bus.req_valid[idx]       = 1'b1;
        #1;
        while (!bus.req_ready[idx] && n < 100) begin
            tick();
            n++;
        end
        check("grant", 32'(bus.req_ready), 32'(1 << idx));
        tick();
        bus.req_valid[idx] = 1'b0;
    endtask

    // Wait for a response, optionally back-pressure it, then compare against the scoreboard
    task automatic wait_rsp(input int hold);
        exp_t e;
        int n = 0;
        while (bus.rsp_valid == '0 && n < 200) begin
            tick();
            n++;
        end
        check("rsp_arrived", 32'(n < 200), 32'd1);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        for (int h = 0; h < hold; h++) begin
            bus.rsp_ready = '1;
            bus.rsp_ready[e.owner] = 1'b0;
            tick();
            check("hold_valid", 32'(bus.rsp_valid), 32'(1 << e.owner));
            check("hold_data", 32'(bus.rsp_data), 32'(e.data));
            check("hold_err", 32'(bus.rsp_err), 32'(e.err));
        end
        check("rsp_owner", 32'(bus.rsp_valid), 32'(1 << e.owner));
        check("rsp_data", 32'(bus.rsp_data), 32'(e.data));
        check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        bus.rsp_ready = '0;
        bus.rsp_ready[e.owner] = 1'b1;
        tick();
        bus.rsp_ready = '0;
        check("rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check("busy_drop", 32'(busy), 32'd0);
    endtask

    initial begin
        int s0;
        int n;
        bus.req_valid = '0;
        bus.req_base  = '0;
        bus.req_exp   = '0;
        bus.req_mod   = '0;
        bus.rsp_ready = '0;

        // Reset state
        tick(); tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(rsa_start), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_mod", 32'(rsa_mod), 32'd0);
        rst_n = 1'b1;
        tick();

        // Requester 0: 65^17 mod 3233, start two cycles after handshake
        s0 = start_cnt;
        push(0, 2790, 0);
        send(0, 12'd65, 12'd17, 12'd3233);
        check("chk_no_start", 32'(rsa_start), 32'd0);
        tick();
        check("issue_start", 32'(rsa_start), 32'd1);
        check("issue_base", 32'(rsa_base), 32'd65);
        check("issue_exp", 32'(rsa_exp), 32'd17);
        check("issue_mod", 32'(rsa_mod), 32'd3233);
        wait_rsp(0);
        check("one_start", 32'(start_cnt - s0), 32'd1);

        // Requester 1: decrypt back to 65
        push(1, 65, 0);
        send(1, 12'd2790, 12'd2753, 12'd3233);
        wait_rsp(0);

        // Both valid: grants alternate 0,1,0,1
        bus.req_base = {12'd65, 12'd4};
        bus.req_exp  = {12'd17, 12'd13};
        bus.req_mod  = {12'd3233, 12'd497};
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            #1;
            while (bus.req_ready == '0 && n < 100) begin
                tick();
                n++;
            end
            check("alt_grant", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
            if (k % 2 == 0) push(0, 445, 0);
            else            push(1, 2790, 0);
            tick();
            wait_rsp(0);
        end
        bus.req_valid = '0;

        // Bad modulus: no engine start, error response two cycles after handshake
        s0 = start_cnt;
        push(0, 0, 1);
        send(0, 12'd5, 12'd3, 12'd1);
        check("badmod_early", 32'(bus.rsp_valid), 32'd0);
        tick();
        check("badmod_valid", 32'(bus.rsp_valid), 32'd1);
        wait_rsp(0);
        check("badmod_nostart", 32'(start_cnt - s0), 32'd0);

        // Watchdog: hung engine gives timeout after 20 WAIT cycles
        eng_hang = 1'b1;
        push(1, 0, 2);
        send(1, 12'd65, 12'd17, 12'd3233);
        tick();
        check("to_start", 32'(rsa_start), 32'd1);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.rsp_valid == '0 && n < 100);
        check("to_latency", 32'(n), 32'd21);
        wait_rsp(0);
        eng_hang = 1'b0;
        push(0, 445, 0);
        send(0, 12'd4, 12'd13, 12'd497);
        wait_rsp(0);

        // Stale done held in CHECK delays the start
        push(1, 2790, 0);
        send(1, 12'd65, 12'd17, 12'd3233);
        stale_done = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stale_nostart", 32'(rsa_start), 32'd0);
            check("stale_busy", 32'(busy), 32'd1);
        end
        stale_done = 1'b0;
        tick();
        check("stale_start", 32'(rsa_start), 32'd1);
        wait_rsp(0);

        // Response back-pressure: held 10 cycles while the other ready is high
        push(1, 65, 0);
        send(1, 12'd2790, 12'd2753, 12'd3233);
        wait_rsp(10);

        // Reset during WAIT abandons the job; next grant goes to requester 0
        send(0, 12'd4, 12'd13, 12'd497);
        tick();
        tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_start", 32'(rsa_start), 32'd0);
        check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
        check("mid_rst_data", 32'(bus.rsp_data), 32'd0);
        check("mid_rst_err", 32'(bus.rsp_err), 32'd0);
        check("mid_rst_base", 32'(rsa_base), 32'd0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        bus.req_base  = {12'd65, 12'd4};
        bus.req_exp   = {12'd17, 12'd13};
        bus.req_mod   = {12'd3233, 12'd497};
        bus.req_valid = 2'b11;
        #1;
        check("post_rst_grant", 32'(bus.req_ready), 32'd1);
        push(0, 445, 0);
        tick();
        bus.req_valid = '0;
        wait_rsp(0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
